// File: rtl/boreal_priv_io_wdt_if.sv
// Register bus between the Gate master and the privileged actuator bank.
// Single outstanding request; slave answers with a one-cycle ack (err coincident).
interface boreal_priv_io_wdt_if;
   logic        sel;
   logic        wr;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (output sel, wr, addr, be, wdata, input rdata, ack, err);
   modport slave  (input sel, wr, addr, be, wdata, output rdata, ack, err);
endinterface

// File: rtl/boreal_priv_io_wdt.sv
// Privileged actuator register bank with heartbeat watchdog forcing SAFE_VALUE on pio_out.
// Optional shadow/commit path for atomic channel updates: define BOREAL_PIO_SHADOW_EN.
module boreal_priv_io_wdt_chan #(
   parameter logic [31:0] SAFE_VALUE = 32'h0
) (
   input  logic [31:0] live,
   input  logic        trip,
   output logic [31:0] pio
);
   assign pio = trip ? SAFE_VALUE : live;
endmodule

module boreal_priv_io_wdt #(
   parameter int unsigned NUM_REGS    = 256,
   parameter int unsigned NUM_OUT     = 4,
   parameter int unsigned WDT_W       = 24,
   parameter int unsigned WDT_TIMEOUT = 1000000,
   parameter logic [31:0] SAFE_VALUE  = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   boreal_priv_io_wdt_if.slave      bus,
   output logic [NUM_OUT*32-1:0]    pio_out,
   output logic                     tripped
);
   localparam int DW = $clog2(NUM_REGS);
   localparam int IW = DW + 1;

   typedef enum logic [1:0] {DISARMED = 2'd0, ARMED = 2'd1, TRIPPED = 2'd2} state_t;

   state_t                       state, state_nxt;
   logic [WDT_W-1:0]             cnt, cnt_nxt;
   logic                         lock, lock_nxt;
   logic [NUM_REGS-1:0][31:0]    regs;
   logic [IW-1:0]                idx;
   logic [DW-1:0]                didx;
   logic                         accept, err_nxt, wr_ok;
   logic                         is_data, is_ctrl, is_stat, is_kick, is_cmt;
   logic                         data_wr, ctrl_wr, kick_wr, shd_hit;
   logic [31:0]                  data_rd, rdata_nxt;
   logic [23:0]                  cnt_ext;
   logic                         unused_addr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] b);
      merge = old;
      for (int j = 0; j < 4; j++)
         if (b[j]) merge[8*j +: 8] = d[8*j +: 8];
   endfunction

   assign accept      = bus.sel & ~bus.ack;
   assign idx         = bus.addr[IW+1:2];
   assign didx        = idx[DW-1:0];
   assign unused_addr = ^{bus.addr[31:IW+2], bus.addr[1:0]};
   assign cnt_ext     = 24'(cnt);

   assign is_data = ~idx[IW-1];
   assign is_ctrl = idx == IW'(NUM_REGS);
   assign is_stat = idx == IW'(NUM_REGS + 1);
   assign is_kick = idx == IW'(NUM_REGS + 2);
   assign is_cmt  = idx == IW'(NUM_REGS + 3);

   // Errored writes never touch state, so every write strobe is gated by err_nxt.
   always_comb begin
      err_nxt = 1'b0;
      if (!(is_data | is_ctrl | is_stat | is_kick | is_cmt)) err_nxt = 1'b1;
      else if (bus.wr && is_stat) err_nxt = 1'b1;
      else if (bus.wr && state == TRIPPED && (is_data | is_kick | is_cmt)) err_nxt = 1'b1;
   end

   assign wr_ok   = accept & bus.wr & ~err_nxt;
   assign data_wr = wr_ok & is_data;
   assign ctrl_wr = wr_ok & is_ctrl;
   assign kick_wr = wr_ok & is_kick;

`ifdef BOREAL_PIO_SHADOW_EN
   logic [NUM_OUT-1:0][31:0] shadow;
   logic                     cmt_wr;

   assign cmt_wr = wr_ok & is_cmt;

   always_comb begin
      shd_hit = 1'b0;
      data_rd = regs[didx];
      for (int k = 0; k < NUM_OUT; k++)
         if (didx == DW'(k)) begin
            shd_hit = 1'b1;
            data_rd = shadow[k];
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow <= '0;
      else begin
         for (int k = 0; k < NUM_OUT; k++)
            if (data_wr && didx == DW'(k)) shadow[k] <= merge(shadow[k], bus.wdata, bus.be);
      end
   end
`else
   assign shd_hit = 1'b0;
   assign data_rd = regs[didx];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs <= '0;
      else begin
         if (data_wr && !shd_hit) regs[didx] <= merge(regs[didx], bus.wdata, bus.be);
`ifdef BOREAL_PIO_SHADOW_EN
         if (cmt_wr) regs[NUM_OUT-1:0] <= shadow;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DISARMED;
         cnt   <= '0;
         lock  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lock  <= lock_nxt;
      end
   end

   // A disarm uses the LOCK already in force; a LOCK in the same write only binds later writes.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lock_nxt  = lock | (ctrl_wr & bus.wdata[2]);
      case (state)
         DISARMED:
            if (ctrl_wr && bus.wdata[0]) begin
               state_nxt = ARMED;
               cnt_nxt   = WDT_W'(WDT_TIMEOUT);
            end
         ARMED:
            if (ctrl_wr && !bus.wdata[0] && !lock) state_nxt = DISARMED;
            else if (kick_wr)                      cnt_nxt   = WDT_W'(WDT_TIMEOUT);
            else if (cnt == '0)                    state_nxt = TRIPPED;
            else                                   cnt_nxt   = cnt - WDT_W'(1);
         TRIPPED:
            if (ctrl_wr && bus.wdata[1]) state_nxt = DISARMED;
         default: state_nxt = DISARMED;
      endcase
   end

   always_comb begin
      rdata_nxt = '0;
      if (!bus.wr) begin
         if (is_data)      rdata_nxt = data_rd;
         else if (is_ctrl) rdata_nxt = {29'b0, lock, 1'b0, state == ARMED};
         else if (is_stat) rdata_nxt = {cnt_ext, 5'b0, lock, state};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ack   <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ack   <= accept;
         bus.err   <= accept & err_nxt;
         bus.rdata <= accept ? rdata_nxt : '0;
      end
   end

   assign tripped = state == TRIPPED;

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      boreal_priv_io_wdt_chan #(.SAFE_VALUE(SAFE_VALUE)) u_chan (
         .live (regs[k]),
         .trip (tripped),
         .pio  (pio_out[32*k +: 32])
      );
   end
endmodule

// File: tb/tb_boreal_priv_io_wdt.sv
// Bench for boreal_priv_io_wdt: transaction-level model of the register map and watchdog,
// compared against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_boreal_priv_io_wdt;
   localparam int          TO   = 16;
   localparam logic [31:0] SAFE = 32'hA5A5_5A5A;
`ifdef BOREAL_PIO_SHADOW_EN
   localparam bit SHD = 1'b1;
`else
   localparam bit SHD = 1'b0;
`endif

   logic         clk, rst_n;
   logic [127:0] pio_out;
   logic         tripped;
   int           passed = 0, total = 0;

   boreal_priv_io_wdt_if bus ();

   boreal_priv_io_wdt #(
      .NUM_REGS(256), .NUM_OUT(4), .WDT_W(24), .WDT_TIMEOUT(TO), .SAFE_VALUE(SAFE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .pio_out(pio_out), .tripped(tripped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model state: register contents, watchdog state (0/1/2), counter, lock, expected bus outputs.
   logic [31:0] m_regs [0:255];
   logic [31:0] m_shd  [0:3];
   logic [1:0]  m_st;
   logic [23:0] m_cnt;
   bit          m_lock;
   bit          e_ack, e_err;
   logic [31:0] e_rd;

   always @(posedge clk or negedge rst_n) begin : model
      logic [31:0] rd, cv, mask;
      bit acc, er, ctl, kick;
      int ix;
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) m_regs[i] = 32'h0;
         for (int i = 0; i < 4; i++) m_shd[i] = 32'h0;
         m_st = 2'd0; m_cnt = 24'd0; m_lock = 1'b0;
         e_ack = 1'b0; e_err = 1'b0; e_rd = 32'h0;
      end else begin
         acc = bus.sel && !e_ack;
         er = 1'b0; rd = 32'h0; ctl = 1'b0; kick = 1'b0; cv = 32'h0;
         ix = int'(bus.addr[10:2]);
         mask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
         if (acc) begin
            if (ix < 256) begin
               if (!bus.wr) rd = (SHD && ix < 4) ? m_shd[ix] : m_regs[ix];
               else if (m_st == 2'd2) er = 1'b1;
               else if (SHD && ix < 4) m_shd[ix] = (m_shd[ix] & ~mask) | (bus.wdata & mask);
               else m_regs[ix] = (m_regs[ix] & ~mask) | (bus.wdata & mask);
            end else if (ix == 256) begin
               if (bus.wr) begin ctl = 1'b1; cv = bus.wdata; end
               else rd = {29'b0, m_lock, 1'b0, m_st == 2'd1};
            end else if (ix == 257) begin
               if (bus.wr) er = 1'b1;
               else rd = {m_cnt, 5'b0, m_lock, m_st};
            end else if (ix == 258 || ix == 259) begin
               if (bus.wr) begin
                  if (m_st == 2'd2) er = 1'b1;
                  else if (ix == 258) kick = 1'b1;
                  else if (SHD) for (int k = 0; k < 4; k++) m_regs[k] = m_shd[k];
               end
            end else er = 1'b1;
         end
         if (m_st == 2'd0) begin
            if (ctl && cv[0]) begin m_st = 2'd1; m_cnt = 24'(TO); end
         end else if (m_st == 2'd1) begin
            if (ctl && !cv[0] && !m_lock) m_st = 2'd0;
            else if (kick) m_cnt = 24'(TO);
            else if (m_cnt == 24'd0) m_st = 2'd2;
            else m_cnt = m_cnt - 24'd1;
         end else if (ctl && cv[1]) m_st = 2'd0;
         if (ctl && cv[2]) m_lock = 1'b1;
         e_ack = acc; e_err = er; e_rd = rd;
      end
   end

   function automatic logic [127:0] exp_pio();
      for (int k = 0; k < 4; k++) exp_pio[32*k +: 32] = (m_st == 2'd2) ? SAFE : m_regs[k];
   endfunction

   always @(negedge clk) begin
      check("ack", bus.ack, e_ack);
      check("err", bus.err, e_err);
      check("rdata", bus.rdata, e_rd);
      check("tripped", tripped, m_st == 2'd2);
      check("pio_out", pio_out, exp_pio());
   end

   task automatic xact(input bit w, input int ix, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
      logic [31:0] a;
      bit done;
      a = $urandom;
      a[10:2] = 9'(ix);
      @(negedge clk);
      bus.sel = 1'b1; bus.wr = w; bus.addr = a; bus.be = b; bus.wdata = d;
      done = 1'b0; rd = 32'h0; er = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         if (bus.ack) begin done = 1'b1; rd = bus.rdata; er = bus.err; end
      end
      if (!done) check("ack_timeout", 1'b0, 1'b1);
      bus.sel = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, d;
      logic        er;
      int          c, ix, r;
      rst_n = 1'b0;
      bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.be = 4'h0; bus.wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_tripped", tripped, 1'b0);
      check("rst_pio", pio_out, 128'h0);
      check("rst_ack", bus.ack, 1'b0);
      rst_n = 1'b1;

      xact(1, 1, 4'b0101, 32'hDEADBEEF, rd, er);
      xact(0, 1, 4'h0, 32'h0, rd, er);
      check("be_merge_rd", rd, 32'h00AD00EF);
      if (!SHD) check("be_merge_pio", pio_out[63:32], 32'h00AD00EF);

      xact(1, 256, 4'hF, 32'h1, rd, er);
      c = 0;
      while (!tripped && c < 40) begin @(negedge clk); c++; end
      check("trip_cycle", c, 17);
      check("trip_safe", pio_out, {4{SAFE}});
      xact(1, 0, 4'hF, 32'h1234, rd, er);
      check("trip_data_err", er, 1'b1);
      xact(1, 256, 4'hF, 32'h2, rd, er);
      check("clear_tripped", tripped, 1'b0);
      xact(0, 257, 4'h0, 32'h0, rd, er);
      check("clear_status", rd, 32'h0);

      xact(1, 256, 4'hF, 32'h1, rd, er);
      repeat (15) @(negedge clk);
      xact(1, 258, 4'hF, 32'h0, rd, er);
      check("expiry_kick_tripped", tripped, 1'b0);
      xact(0, 257, 4'h0, 32'h0, rd, er);
      check("expiry_kick_status", rd, 32'h00000F01);

      xact(0, 261, 4'h0, 32'h0, rd, er);
      check("bad_idx_err", er, 1'b1);
      check("bad_idx_rdata", rd, 32'h0);
      xact(0, 258, 4'h0, 32'h0, rd, er);
      check("kick_rd_err", er, 1'b0);
      check("kick_rd_data", rd, 32'h0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: ix = $urandom_range(0, 7);
            4:          ix = $urandom_range(0, 255);
            5, 6:       ix = 258;
            7:          ix = 256 + $urandom_range(0, 3);
            8:          ix = $urandom_range(0, 1) ? 259 : 257;
            default:    ix = $urandom_range(260, 511);
         endcase
         d = $urandom;
         if (ix == 256) d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 19) == 0) ? 32'h4 : 32'h0);
         xact(1'($urandom_range(0, 1)), ix, 4'($urandom), d, rd, er);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 32'h14; bus.be = 4'hF; bus.wdata = 32'hCAFE0005;
      #2 rst_n = 1'b0;
      bus.sel = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xact(0, 5, 4'h0, 32'h0, rd, er);
      check("midrst_write_dropped", rd, 32'h0);
      xact(0, 257, 4'h0, 32'h0, rd, er);
      check("midrst_status", rd, 32'h0);

`ifdef BOREAL_PIO_SHADOW_EN
      for (int k = 0; k < 4; k++) xact(1, k, 4'hF, 32'(k + 1), rd, er);
      check("shadow_pio_held", pio_out, 128'h0);
      xact(1, 259, 4'hF, 32'h0, rd, er);
      check("shadow_commit", pio_out, {32'd4, 32'd3, 32'd2, 32'd1});
      xact(0, 2, 4'h0, 32'h0, rd, er);
      check("shadow_rd", rd, 32'd3);
`endif

      xact(1, 256, 4'hF, 32'h5, rd, er);
      xact(1, 256, 4'hF, 32'h0, rd, er);
      check("lock_disarm_err", er, 1'b0);
      xact(0, 257, 4'h0, 32'h0, rd, er);
      check("lock_hold", rd[2:0], 3'b101);
      c = 0;
      while (!tripped && c < 60) begin @(negedge clk); c++; end
      check("lock_trip", tripped, 1'b1);
      xact(1, 256, 4'hF, 32'h2, rd, er);
      check("lock_clear", tripped, 1'b0);
      xact(0, 257, 4'h0, 32'h0, rd, er);
      check("lock_clear_status", rd[2:0], 3'b100);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
